// File: rtl/rsa_pkg.sv
// Shared RSA definitions: default datapath width and the state encodings
// used by the modular exponentiation engine and its multiplier.
package rsa_pkg;

  localparam int RSA_W = 16;

  // ME_NEXT is kept for completeness; it is folded into the last multiplier cycle.
  typedef enum logic [2:0] {
    ME_IDLE,
    ME_LOAD,
    ME_SQR,
    ME_MUL,
    ME_NEXT,
    ME_DONE
  } mod_exp_state_t;

  typedef enum logic {
    MM_IDLE,
    MM_RUN
  } mod_mul_state_t;

endpackage

// File: rtl/mod_mul.sv
// Interleaved shift-add modular multiplier, p = a*b mod n, MSB-first over b.
// Takes exactly W+1 cycles: one issue cycle plus W iterations; p is valid while done is high.
module mod_mul
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] p,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(W);

  mod_mul_state_t state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic [W-1:0]   n_r;
  logic [W-1:0]   p_r;
  logic [CW-1:0]  cnt;

  logic [W:0]     n_ext;
  logic [W:0]     dbl;
  logic [W:0]     dbl_red;
  logic [W:0]     sum;
  logic [W-1:0]   p_next;

  // One iteration: double, reduce, conditionally add a, reduce again.
  always_comb begin
    n_ext   = {1'b0, n_r};
    dbl     = {p_r, 1'b0};
    dbl_red = (dbl >= n_ext) ? (dbl - n_ext) : dbl;
    sum     = dbl_red + {1'b0, a_r & {W{b_r[W-1]}}};
    p_next  = (sum >= n_ext) ? W'(sum - n_ext) : sum[W-1:0];
  end

  assign p    = p_next;
  assign busy = (state == MM_RUN);
  assign done = (state == MM_RUN) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MM_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      n_r   <= '0;
      p_r   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        MM_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            n_r   <= n;
            p_r   <= '0;
            cnt   <= CW'(W - 1);
            state <= MM_RUN;
          end
        end
        MM_RUN: begin
          p_r <= p_next;
          b_r <= {b_r[W-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= MM_IDLE;
          end
        end
        default: state <= MM_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mod_exp.sv
// Left-to-right square-and-multiply modular exponentiation over all W exponent bits.
// Latency is 2 + (W+1)*(W + popcount(exp)) cycles by design; it is the side channel under study.
module mod_exp
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         done
);

  localparam int IW = $clog2(W);

  mod_exp_state_t state;
  logic [W-1:0]   base_r;
  logic [W-1:0]   exp_r;
  logic [W-1:0]   mod_r;
  logic [W-1:0]   acc;
  logic [IW-1:0]  idx;

  logic           mul_start;
  logic [W-1:0]   mul_b;
  logic [W-1:0]   mul_p;
  logic           mul_busy;
  logic           mul_done;

  // The single multiplier is re-issued the cycle after it finishes, so each op costs W+1 cycles.
  assign mul_start = ((state == ME_SQR) || (state == ME_MUL)) && !mul_busy;
  assign mul_b     = (state == ME_MUL) ? base_r : acc;

  mod_mul #(.W(W)) u_mod_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (acc),
    .b     (mul_b),
    .n     (mod_r),
    .p     (mul_p),
    .busy  (mul_busy),
    .done  (mul_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ME_IDLE;
      base_r <= '0;
      exp_r  <= '0;
      mod_r  <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ME_IDLE: begin
          if (start) begin
            base_r <= base;
            exp_r  <= exp;
            mod_r  <= modulus;
            busy   <= 1'b1;
            state  <= ME_LOAD;
          end
        end
        ME_LOAD: begin
          if (mod_r < W'(2)) begin
            acc   <= '0;
            state <= ME_DONE;
          end else begin
            acc   <= W'(1);
            idx   <= IW'(W - 1);
            state <= ME_SQR;
          end
        end
        ME_SQR: begin
          if (mul_done) begin
            acc <= mul_p;
            if (exp_r[idx]) begin
              state <= ME_MUL;
            end else if (idx == '0) begin
              state <= ME_DONE;
            end else begin
              idx <= idx - IW'(1);
            end
          end
        end
        // Bit advance happens here on the multiplier's final cycle instead of in a separate state.
        ME_MUL: begin
          if (mul_done) begin
            acc <= mul_p;
            if (idx == '0) begin
              state <= ME_DONE;
            end else begin
              idx   <= idx - IW'(1);
              state <= ME_SQR;
            end
          end
        end
        ME_DONE: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= ME_IDLE;
        end
        default: state <= ME_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp.sv
// Directed self-checking bench for mod_exp: hand-computed RSA vectors, exact latency,
// ignored mid-run start, asynchronous abort and back-to-back restart.
module tb_mod_exp;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] base = '0;
  logic [W-1:0] exp = '0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] result;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  mod_exp #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base    (base),
    .exp     (exp),
    .modulus (modulus),
    .result  (result),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives operands with start high; returns #1 after the accepting edge (edge 0).
  task automatic applyStimulus(input int b, input int e, input int m);
    base    = W'(b);
    exp     = W'(e);
    modulus = W'(m);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done; optionally pulses a junk start at edge inject_at.
  task automatic runOp(input string tag, input int exp_result, input int exp_latency, input int inject_at);
    int lat;
    bit busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (k == inject_at) begin
        start   = 1'b1;
        base    = 16'd7;
        exp     = 16'hFFFF;
        modulus = 16'd11;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput({tag, "_latency"}, lat, exp_latency);
    checkOutput({tag, "_result"}, {16'd0, result}, exp_result);
    checkOutput({tag, "_busy_in_done_cycle"}, {31'd0, busy}, 0);
    checkOutput({tag, "_busy_while_running"}, {31'd0, busy_ok}, 1);
  endtask

  initial begin
    bit seen;

    #12;
    checkOutput("reset_result", {16'd0, result}, 0);
    checkOutput("reset_busy", {31'd0, busy}, 0);
    checkOutput("reset_done", {31'd0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] 65^17 mod 3233");
    applyStimulus(65, 17, 3233);
    runOp("enc", 2790, 308, 0);
    @(posedge clk);
    #1;
    checkOutput("enc_done_single_pulse", {31'd0, done}, 0);
    checkOutput("enc_busy_after", {31'd0, busy}, 0);
    checkOutput("enc_result_held", {16'd0, result}, 2790);

    $display("[TB] 2790^2753 mod 3233 with ignored start");
    @(negedge clk);
    applyStimulus(2790, 2753, 3233);
    runOp("dec", 65, 359, 150);

    $display("[TB] 4^13 mod 497");
    @(negedge clk);
    applyStimulus(4, 13, 497);
    runOp("small", 445, 325, 0);

    $display("[TB] reset in the middle of a run");
    @(negedge clk);
    applyStimulus(65, 17, 3233);
    for (int k = 1; k < 100; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abort_busy_before", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_result", {16'd0, result}, 0);
    checkOutput("abort_busy", {31'd0, busy}, 0);
    checkOutput("abort_done", {31'd0, done}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checkOutput("abort_no_done", {31'd0, seen}, 0);

    $display("[TB] restart after abort, then back-to-back start");
    @(negedge clk);
    applyStimulus(65, 17, 3233);
    runOp("restart", 2790, 308, 0);
    applyStimulus(4, 13, 497);
    runOp("b2b", 445, 325, 0);

    $display("[TB] zero exponent and degenerate modulus");
    @(negedge clk);
    applyStimulus(4, 0, 497);
    runOp("exp0", 1, 274, 0);
    @(negedge clk);
    applyStimulus(0, 5, 1);
    runOp("mod1", 0, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
